// File: rtl/ssr_pkg.sv
// ssr_pkg: shared widths, FSM states and error bit indices for the SSR byte source
package ssr_pkg;
  localparam int BYTE_W    = 8;
  localparam int ERR_OVF   = 0;
  localparam int ERR_PROTO = 1;
  typedef enum logic [1:0] {IDLE, WAIT_DATA, PRESENT, WAIT_ACK_LOW} state_e;
endpackage

// File: rtl/ssr_byte_fifo.sv
// ssr_byte_fifo: circular byte buffer with guarded push/pop and occupancy count
module ssr_byte_fifo
  import ssr_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [BYTE_W-1:0] wdata_i,
  output logic [BYTE_W-1:0] rdata_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [LW-1:0]     level_o
);
  logic [BYTE_W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [LW-1:0] level_q;
  logic do_push, do_pop;
  assign full_o  = level_q == LW'(DEPTH);
  assign empty_o = level_q == '0;
  assign level_o = level_q;
  assign rdata_o = mem_q[rptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  // Storage array; contents need no reset since pointers define validity
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end
  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= do_push ? wptr_q + AW'(1) : wptr_q;
      rptr_q  <= do_pop ? rptr_q + AW'(1) : rptr_q;
      level_q <= level_q + LW'(do_push) - LW'(do_pop);
    end
  end
endmodule

// File: rtl/ssr_byte_source.sv
// ssr_byte_source: FIFO-backed producer side of the four-phase SSR byte handshake
module ssr_byte_source
  import ssr_pkg::*;
#(
  parameter int          DEPTH       = 16,
  parameter int          SYNC_STAGES = 2,
  parameter logic [15:0] SERVED_INIT = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [BYTE_W-1:0]        wr_data,
  output logic                     fifo_full,
  output logic [$clog2(DEPTH):0]   fifo_level,
  input  logic                     readssr_req,
  input  logic                     byte_received_ack,
  output logic [BYTE_W-1:0]        byte_out,
  output logic                     byte_ready,
  output logic [15:0]              bytes_served,
  output logic [1:0]               err
);
  logic [SYNC_STAGES-1:0] req_sync_q, ack_sync_q;
  logic req_s, ack_s, pop, fifo_empty;
  logic [BYTE_W-1:0] fifo_rdata, byte_out_q;
  logic [15:0] served_q, served_d;
  logic [1:0] err_q, err_d;
  state_e state_q, state_d;
  assign req_s        = req_sync_q[SYNC_STAGES-1];
  assign ack_s        = ack_sync_q[SYNC_STAGES-1];
  assign byte_ready   = state_q == PRESENT;
  assign byte_out     = byte_out_q;
  assign bytes_served = served_q;
  assign err          = err_q;
  ssr_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (wr_en),
    .pop_i   (pop),
    .wdata_i (wr_data),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );
  // CPU strobes come from another clock domain; shift them through plain synchroniser chains
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_sync_q <= '0;
      ack_sync_q <= '0;
    end else begin
      req_sync_q <= {req_sync_q[SYNC_STAGES-2:0], readssr_req};
      ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], byte_received_ack};
    end
  end
  // Handshake sequencing; byte_ready is decoded from the registered state so reset drops it at once
  always_comb begin
    state_d = state_q;
    served_d = served_q;
    err_d = err_q;
    pop = 1'b0;
    if (wr_en && fifo_full) err_d[ERR_OVF] = 1'b1;
    case (state_q)
      IDLE: begin
        if (ack_s) err_d[ERR_PROTO] = 1'b1;
        else if (req_s) begin
          pop = !fifo_empty;
          state_d = fifo_empty ? WAIT_DATA : PRESENT;
        end
      end
      WAIT_DATA: begin
        if (ack_s) err_d[ERR_PROTO] = 1'b1;
        if (!req_s) state_d = IDLE;
        else if (!fifo_empty) begin
          pop = 1'b1;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (ack_s) begin
          served_d = served_q + 16'd1;
          state_d = WAIT_ACK_LOW;
        end else if (!req_s) begin
          err_d[ERR_PROTO] = 1'b1;
          state_d = IDLE;
        end
      end
      WAIT_ACK_LOW: state_d = ack_s ? WAIT_ACK_LOW : IDLE;
      default: state_d = IDLE;
    endcase
  end
  // State, counters and the presented byte; byte_out only loads on a pop so it holds otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      served_q   <= SERVED_INIT;
      err_q      <= '0;
      byte_out_q <= '0;
    end else begin
      state_q    <= state_d;
      served_q   <= served_d;
      err_q      <= err_d;
      byte_out_q <= pop ? fifo_rdata : byte_out_q;
    end
  end
endmodule

// File: tb/tb_ssr_byte_source.sv
// tb_ssr_byte_source: scoreboard bench for the SSR byte source handshake
module tb_ssr_byte_source;
  localparam int DEPTH = 16;
  localparam int SS = 2;
  logic clk = 1'b0;
  logic rst;
  logic wr_en, readssr_req, byte_received_ack, fifo_full, byte_ready;
  logic [7:0] wr_data, byte_out;
  logic [4:0] fifo_level;
  logic [15:0] bytes_served;
  logic [1:0] err;
  logic wr_en2, req2, ack2, full2, ready2;
  logic [7:0] wr_data2, byte_out2;
  logic [4:0] level2;
  logic [15:0] served2;
  logic [1:0] err2;
  int tests = 0;
  int fails = 0;
  logic [7:0] q1[$];
  logic [7:0] q2[$];
  always #5 clk = ~clk;
  ssr_byte_source #(.DEPTH(DEPTH), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .fifo_full(fifo_full), .fifo_level(fifo_level),
    .readssr_req(readssr_req), .byte_received_ack(byte_received_ack),
    .byte_out(byte_out), .byte_ready(byte_ready),
    .bytes_served(bytes_served), .err(err)
  );
  ssr_byte_source #(.DEPTH(DEPTH), .SYNC_STAGES(SS), .SERVED_INIT(16'hFFFE)) dut2 (
    .clk(clk), .rst(rst), .wr_en(wr_en2), .wr_data(wr_data2),
    .fifo_full(full2), .fifo_level(level2),
    .readssr_req(req2), .byte_received_ack(ack2),
    .byte_out(byte_out2), .byte_ready(ready2),
    .bytes_served(served2), .err(err2)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask
  // Monitors: pop an expected byte on each byte_ready rise, then demand stability while high
  logic prev1 = 1'b0, prev2 = 1'b0;
  logic [7:0] held1, held2;
  always @(negedge clk) begin
    logic [7:0] e;
    if (byte_ready) begin
      tests++;
      if (!prev1) begin
        held1 = byte_out;
        if (q1.size() == 0) begin
          fails++;
          $display("FAIL mon1_byte: got %0h, no byte expected", byte_out);
        end else begin
          e = q1.pop_front();
          if (byte_out !== e) begin
            fails++;
            $display("FAIL mon1_byte: got %0h, expected %0h", byte_out, e);
          end
        end
      end else if (byte_out !== held1) begin
        fails++;
        $display("FAIL mon1_stable: got %0h, expected %0h", byte_out, held1);
      end
    end
    prev1 = byte_ready;
  end
  always @(negedge clk) begin
    logic [7:0] e;
    if (ready2) begin
      tests++;
      if (!prev2) begin
        held2 = byte_out2;
        if (q2.size() == 0) begin
          fails++;
          $display("FAIL mon2_byte: got %0h, no byte expected", byte_out2);
        end else begin
          e = q2.pop_front();
          if (byte_out2 !== e) begin
            fails++;
            $display("FAIL mon2_byte: got %0h, expected %0h", byte_out2, e);
          end
        end
      end else if (byte_out2 !== held2) begin
        fails++;
        $display("FAIL mon2_stable: got %0h, expected %0h", byte_out2, held2);
      end
    end
    prev2 = ready2;
  end
  task automatic wait_rdy(input bit two, input logic val, input int maxc, output int n);
    bit hit;
    n = 0;
    hit = 0;
    while (!hit && n < maxc) begin
      @(posedge clk);
      #1;
      n++;
      hit = ((two ? ready2 : byte_ready) === val);
    end
    if (!hit) begin
      tests++;
      fails++;
      $display("FAIL wait_rdy: byte_ready got %0b, expected %0b within %0d cycles", !val, val, maxc);
      n = -1;
    end
  endtask
  task automatic wr1(input logic [7:0] d);
    if (q1.size() < DEPTH) q1.push_back(d);
    wr_en = 1'b1;
    wr_data = d;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask
  task automatic wr2(input logic [7:0] d);
    q2.push_back(d);
    wr_en2 = 1'b1;
    wr_data2 = d;
    @(posedge clk);
    #1;
    wr_en2 = 1'b0;
  endtask
  task automatic xfer1();
    int n;
    readssr_req = 1'b1;
    wait_rdy(0, 1'b1, 20, n);
    chk("req_latency", n, SS + 1);
    byte_received_ack = 1'b1;
    wait_rdy(0, 1'b0, 20, n);
    chk("ack_latency", n, SS + 1);
    readssr_req = 1'b0;
    byte_received_ack = 1'b0;
    repeat (SS + 2) @(posedge clk);
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int n;
    logic [15:0] srv_tab [3];
    srv_tab = '{16'hFFFF, 16'h0000, 16'h0001};
    rst = 1'b1;
    {wr_en, readssr_req, byte_received_ack, wr_en2, req2, ack2} = '0;
    wr_data = '0;
    wr_data2 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", byte_ready, 0);
    chk("rst_byte_out", byte_out, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_full", fifo_full, 0);
    chk("rst_served", bytes_served, 0);
    chk("rst_err", err, 0);
    chk("rst_served2", served2, 16'hFFFE);
    rst = 1'b0;
    // Two ordinary transfers
    wr1(8'hA5);
    wr1(8'h3C);
    chk("two_level", fifo_level, 2);
    xfer1();
    xfer1();
    chk("two_served", bytes_served, 2);
    chk("two_level_after", fifo_level, 0);
    chk("two_err", err, 0);
    // Request with empty FIFO, byte arrives later
    readssr_req = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("wd_no_ready", byte_ready, 0);
    wr1(8'h7E);
    chk("wd_ready_at_write", byte_ready, 0);
    chk("wd_level_at_write", fifo_level, 1);
    @(posedge clk);
    #1;
    chk("wd_ready_next", byte_ready, 1);
    chk("wd_byte", byte_out, 8'h7E);
    chk("wd_level_popped", fifo_level, 0);
    byte_received_ack = 1'b1;
    wait_rdy(0, 1'b0, 20, n);
    readssr_req = 1'b0;
    byte_received_ack = 1'b0;
    repeat (SS + 2) @(posedge clk);
    #1;
    chk("wd_served", bytes_served, 3);
    // Overflow: 17 writes into a 16-deep FIFO
    for (int i = 0; i < 17; i++) wr1(8'h10 + 8'(i));
    chk("ovf_full", fifo_full, 1);
    chk("ovf_level", fifo_level, 16);
    chk("ovf_err", err, 2'b01);
    for (int i = 0; i < 16; i++) xfer1();
    chk("ovf_drained", fifo_level, 0);
    chk("ovf_not_full", fifo_full, 0);
    chk("ovf_served", bytes_served, 19);
    // Request dropped while PRESENT
    wr1(8'h55);
    chk("drop_level_before", fifo_level, 1);
    readssr_req = 1'b1;
    wait_rdy(0, 1'b1, 20, n);
    readssr_req = 1'b0;
    wait_rdy(0, 1'b0, 20, n);
    chk("drop_latency", n, SS + 1);
    chk("drop_err", err, 2'b11);
    chk("drop_level", fifo_level, 0);
    chk("drop_served", bytes_served, 19);
    repeat (SS + 2) @(posedge clk);
    #1;
    // Back-to-back transfers on the preloaded instance, req held high
    wr2(8'hC1);
    wr2(8'hC2);
    wr2(8'hC3);
    req2 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_rdy(1, 1'b1, 20, n);
      ack2 = 1'b1;
      wait_rdy(1, 1'b0, 20, n);
      chk("b2b_served", served2, srv_tab[i]);
      ack2 = 1'b0;
    end
    repeat (SS + 2) @(posedge clk);
    #1;
    chk("b2b_level", level2, 0);
    chk("b2b_err", err2, 0);
    req2 = 1'b0;
    // Reset in the middle of a transfer
    wr1(8'h66);
    wr1(8'h67);
    readssr_req = 1'b1;
    wait_rdy(0, 1'b1, 20, n);
    chk("mid_level", fifo_level, 1);
    rst = 1'b1;
    q1.delete();
    #2;
    chk("mid_rst_ready", byte_ready, 0);
    chk("mid_rst_byte_out", byte_out, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mid_level_after", fifo_level, 0);
    chk("mid_served_after", bytes_served, 0);
    chk("mid_err_after", err, 0);
    repeat (10) @(posedge clk);
    #1;
    chk("mid_no_ready", byte_ready, 0);
    wr1(8'h99);
    wait_rdy(0, 1'b1, 5, n);
    chk("mid_write_latency", n, 1);
    byte_received_ack = 1'b1;
    wait_rdy(0, 1'b0, 20, n);
    readssr_req = 1'b0;
    byte_received_ack = 1'b0;
    repeat (SS + 2) @(posedge clk);
    #1;
    chk("mid_served_final", bytes_served, 1);
    chk("q1_drained", q1.size(), 0);
    chk("q2_drained", q2.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ssr_byte_source.md
Name: ssr_byte_source

Overview:
Producer end of the SSR byte handshake. The CPU consumes bytes through byte_in, readssr_req, byte_received_ack and byte_ready; this block drives that interface from the other side.
- Bytes are loaded by a host-side write port into a small FIFO.
- The block serves them one per four-phase handshake.
- It runs on the free-running board clock. CPU-side strobes come from the gated processor clock domain and are synchronised on entry.

Parameters:
DEPTH, 16, FIFO depth in bytes; power of two, >= 2
SYNC_STAGES, 2, flops in each input synchroniser (readssr_req, byte_received_ack); >= 2

Ports:
clk  in  1  board clock; all state updates on posedge
rst  in  1  reset, asynchronous, active-high
wr_en  in  1  host write strobe; one byte per cycle
wr_data  in  8  host write byte
fifo_full  out  1  FIFO holds DEPTH bytes
fifo_level  out  $clog2(DEPTH)+1  bytes currently held, 0..DEPTH
readssr_req  in  1  CPU request (async to clk)
byte_received_ack  in  1  CPU acknowledge (async to clk)
byte_out  out  8  byte presented; connects to CPU byte_in
byte_ready  out  1  byte_out valid
bytes_served  out  16  completed transfers, wraps at 65535 -> 0
err  out  2  sticky: [0] write overflow, [1] protocol violation

Behaviour:
Reset: all outputs 0; FIFO emptied; FSM=IDLE; synchroniser flops 0. Reset mid-transfer drops byte_ready within the reset assertion, with no extra cycle.

Sync:
- req_s and ack_s are the SYNC_STAGES-delayed versions of readssr_req and byte_received_ack.
- The FSM uses only req_s and ack_s.

FIFO:
- Circular buffer.
- Write accepted when wr_en && !fifo_full. wr_en while full drops the byte and sets err[0].
- Pop only when level > 0 at the start of the cycle. No write-to-read bypass: a byte written into an empty FIFO is poppable the next cycle.
- Simultaneous push and pop leaves level unchanged.

FSM (registered outputs):
- IDLE: byte_ready=0.
  - req_s && !ack_s: if level>0, pop, load byte_out -> PRESENT; else -> WAIT_DATA.
  - ack_s=1 sets err[1] and stays in IDLE.
- WAIT_DATA:
  - !req_s -> IDLE (CPU abort, no error).
  - level>0 -> pop, load byte_out -> PRESENT.
  - ack_s=1 sets err[1].
- PRESENT: byte_ready=1; byte_out held stable.
  - ack_s=1 -> byte_ready<=0, bytes_served++ -> WAIT_ACK_LOW.
  - !req_s && !ack_s -> byte discarded, err[1] set, byte_ready<=0 -> IDLE.
- WAIT_ACK_LOW: byte_ready=0.
  - !ack_s -> IDLE.
  - req_s may remain high; the next transfer starts from IDLE on the following cycle.

Latency and output rules:
- Pin rise of readssr_req to byte_ready=1 is SYNC_STAGES+1 clk cycles when the FIFO is non-empty.
- Pin rise of byte_received_ack to byte_ready=0 is SYNC_STAGES+1 cycles.
- byte_out keeps its last value outside PRESENT and never changes while byte_ready=1.
- err bits are cleared only by rst.

Decomposition:
Package ssr_pkg holds:
- BYTE_W=8
- FSM state enum (IDLE, WAIT_DATA, PRESENT, WAIT_ACK_LOW)
- ERR_OVF=0 and ERR_PROTO=1 bit indices

Sub-module ssr_byte_fifo (parameter DEPTH; push, pop, data in/out, full, empty, level). The synchronisers stay inline.

Test Plan:
- Write 0xA5, 0x3C; run two full handshakes -> byte_out=0xA5, then 0x3C, each stable while byte_ready=1; bytes_served=2; fifo_level=0; err=0.
- Raise req with FIFO empty, write 0x7E 10 cycles later -> byte_ready rises 2 cycles after the write (pop the following cycle, registered output); byte_out=0x7E.
- Write 17 bytes with DEPTH=16 -> fifo_full=1, fifo_level=16, err[0]=1; bytes served are the first 16 in order.
- Drop req while PRESENT without ack -> byte_ready=0 after SYNC_STAGES+1 cycles, err[1]=1, fifo_level decremented by 1, bytes_served unchanged.
- Assert rst during PRESENT -> byte_ready=0 during the reset assertion; after release fifo_level=0, bytes_served=0, err=0, and req-high with ack-low produces no byte_ready until a byte is written.
- Hold req high across 3 back-to-back transfers, toggling only ack -> 3 bytes delivered; bytes_served starting from preload 0xFFFE wraps to 0x0001.
